alu_issue: RTL and testbench

Execute-stage issue register for the five-stage MIPS pipeline: the producing end of the ALU interface. Decodes the D-stage instruction into an ALUOP code plus A/B operands, detects load-use hazards, and registers everything into the E stage with stall, flush and bubble handling. Its E-stage outputs drive the ALU inputs directly; `equal` from the ALU is not consumed here.

---
 rtl/alu_issue_pkg.sv | 56 +++++
 rtl/alu_issue_dec.sv | 79 +++++++
 rtl/alu_issue.sv | 107 ++++++++++
 tb/tb_alu_issue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the E-stage issue register: opcodes, ALUOP codes,
// the E-stage bundle and the decoder result record.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_t;

  typedef struct packed {
    logic [3:0]  aluop;
    logic        imm_sel;
    ext_mode_t   ext;
    logic [4:0]  dest;
    logic        reads_rs;
    logic        reads_rt;
    logic        mem_read;
    logic        mem_write;
    logic        legal;
  } dec_t;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] rt_val;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
  } e_stage_t;

  localparam e_stage_t E_BUBBLE = '0;

  function automatic logic [31:0] extend_imm(logic [15:0] imm, ext_mode_t mode);
    if (mode == EXT_SIGN) return {{16{imm[15]}}, imm};
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decoder for the D-stage instruction: ALUOP, operand-B source,
// immediate extension, destination, source-read flags and memory flags.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  // Register indices for hazard compares are taken directly by the top.
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec = '0;
    unique case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          dec.aluop    = (fn == FN_ADDU) ? ALU_ADD : ALU_SUB;
          dec.dest     = rd;
          dec.reads_rs = 1'b1;
          dec.reads_rt = 1'b1;
          dec.legal    = 1'b1;
        end
      end
      OP_ORI: begin
        dec.aluop    = ALU_OR;
        dec.imm_sel  = 1'b1;
        dec.ext      = EXT_ZERO;
        dec.dest     = rt;
        dec.reads_rs = 1'b1;
        dec.legal    = 1'b1;
      end
      OP_LUI: begin
        dec.aluop    = ALU_LUI;
        dec.imm_sel  = 1'b1;
        dec.ext      = EXT_ZERO;
        dec.dest     = rt;
        dec.legal    = 1'b1;
      end
      OP_LW: begin
        dec.aluop    = ALU_ADD;
        dec.imm_sel  = 1'b1;
        dec.ext      = EXT_SIGN;
        dec.dest     = rt;
        dec.reads_rs = 1'b1;
        dec.mem_read = 1'b1;
        dec.legal    = 1'b1;
      end
      OP_SW: begin
        // rt is read as store data, so it participates in load-use detection.
        dec.aluop     = ALU_ADD;
        dec.imm_sel   = 1'b1;
        dec.ext       = EXT_SIGN;
        dec.reads_rs  = 1'b1;
        dec.reads_rt  = 1'b1;
        dec.mem_write = 1'b1;
        dec.legal     = 1'b1;
      end
      OP_BEQ: begin
        dec.aluop    = ALU_SUB;
        dec.reads_rs = 1'b1;
        dec.reads_rt = 1'b1;
        dec.legal    = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// E-stage issue register: decode, load-use hazard detection, operand bypass and
// the E pipeline register. Optional operand forwarding under `ALU_ISSUE_FWD_EN.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        stall_ext,
`ifdef ALU_ISSUE_FWD_EN
  input  logic        fwd_m_we,
  input  logic [4:0]  fwd_m_reg,
  input  logic [31:0] fwd_m_data,
  input  logic        fwd_w_we,
  input  logic [4:0]  fwd_w_reg,
  input  logic [31:0] fwd_w_data,
`endif
  output logic        stall_d,
  output logic [3:0]  ALUOP,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [31:0] rt_e,
  output logic [4:0]  wr_reg_e,
  output logic        reg_write_e,
  output logic        mem_read_e,
  output logic        mem_write_e,
  output logic        valid_e
);

  dec_t        dec;
  e_stage_t    e_q;
  e_stage_t    e_d;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        load_in_e;
  logic        src_hit;

  assign rs_idx = instr_d[25:21];
  assign rt_idx = instr_d[20:16];

  alu_issue_dec u_dec (
    .instr (instr_d),
    .dec   (dec)
  );

  always_comb begin
    rs_val = rs_data;
    rt_val = rt_data;
`ifdef ALU_ISSUE_FWD_EN
    // W applied first so a matching M overrides it.
    if (fwd_w_we && fwd_w_reg != 5'd0 && fwd_w_reg == rs_idx) rs_val = fwd_w_data;
    if (fwd_m_we && fwd_m_reg != 5'd0 && fwd_m_reg == rs_idx) rs_val = fwd_m_data;
    if (fwd_w_we && fwd_w_reg != 5'd0 && fwd_w_reg == rt_idx) rt_val = fwd_w_data;
    if (fwd_m_we && fwd_m_reg != 5'd0 && fwd_m_reg == rt_idx) rt_val = fwd_m_data;
`endif
  end

  // Stall/valid handshake: valid_d qualifies instr_d; stall_d asks F/D to hold the
  // same instruction for one more cycle while E takes a bubble. stall_ext freezes E
  // entirely and masks stall_d; flush overrides both and always loads a bubble.
  assign load_in_e = e_q.valid && e_q.mem_read && (e_q.wr_reg != 5'd0);
  assign src_hit   = (dec.reads_rs && rs_idx == e_q.wr_reg) ||
                     (dec.reads_rt && rt_idx == e_q.wr_reg);
  assign stall_d   = !stall_ext && load_in_e && valid_d && dec.legal && src_hit;

  always_comb begin
    e_d = E_BUBBLE;
    if (valid_d && dec.legal) begin
      e_d.aluop     = dec.aluop;
      e_d.alu_a     = dec.reads_rs ? rs_val : 32'h0;
      e_d.alu_b     = dec.imm_sel ? extend_imm(instr_d[15:0], dec.ext) : rt_val;
      e_d.rt_val    = rt_val;
      e_d.wr_reg    = dec.dest;
      e_d.reg_write = (dec.dest != 5'd0);
      e_d.mem_read  = dec.mem_read;
      e_d.mem_write = dec.mem_write;
      e_d.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= E_BUBBLE;
    end else if (flush) begin
      e_q <= E_BUBBLE;
    end else if (!stall_ext) begin
      e_q <= stall_d ? E_BUBBLE : e_d;
    end
  end

  assign ALUOP       = e_q.aluop;
  assign ALU_A       = e_q.alu_a;
  assign ALU_B       = e_q.alu_b;
  assign rt_e        = e_q.rt_val;
  assign wr_reg_e    = e_q.wr_reg;
  assign reg_write_e = e_q.reg_write;
  assign mem_read_e  = e_q.mem_read;
  assign mem_write_e = e_q.mem_write;
  assign valid_e     = e_q.valid;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: instruction-level model with per-cycle compare
// plus directed literal checks. Forwarding cases run when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        stall_ext;
  logic        fwd_m_we;
  logic [4:0]  fwd_m_reg;
  logic [31:0] fwd_m_data;
  logic        fwd_w_we;
  logic [4:0]  fwd_w_reg;
  logic [31:0] fwd_w_data;
  logic        stall_d;
  logic [3:0]  ALUOP;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [31:0] rt_e;
  logic [4:0]  wr_reg_e;
  logic        reg_write_e;
  logic        mem_read_e;
  logic        mem_write_e;
  logic        valid_e;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .valid_d     (valid_d),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .stall_ext   (stall_ext),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_m_we    (fwd_m_we),
    .fwd_m_reg   (fwd_m_reg),
    .fwd_m_data  (fwd_m_data),
    .fwd_w_we    (fwd_w_we),
    .fwd_w_reg   (fwd_w_reg),
    .fwd_w_data  (fwd_w_data),
`endif
    .stall_d     (stall_d),
    .ALUOP       (ALUOP),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .rt_e        (rt_e),
    .wr_reg_e    (wr_reg_e),
    .reg_write_e (reg_write_e),
    .mem_read_e  (mem_read_e),
    .mem_write_e (mem_write_e),
    .valid_e     (valid_e)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        v;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  exp_t m_e = '0;

  function automatic logic [31:0] src_val(logic [4:0] idx, logic [31:0] rf);
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_m_we && fwd_m_reg != 0 && fwd_m_reg == idx) return fwd_m_data;
    if (fwd_w_we && fwd_w_reg != 0 && fwd_w_reg == idx) return fwd_w_data;
`endif
    return rf;
  endfunction

  // What the E stage must hold for one instruction, by mnemonic.
  function automatic exp_t model_issue(logic [31:0] ins, logic vld, logic [31:0] rsv, logic [31:0] rtv);
    exp_t e;
    logic [31:0] zimm, simm;
    e = '0;
    zimm = {16'h0, ins[15:0]};
    simm = {{16{ins[15]}}, ins[15:0]};
    if (!vld) return e;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21)      begin e.aluop = 0; e.a = rsv; e.b = rtv; e.wr = ins[15:11]; end
        else if (ins[5:0] == 6'h23) begin e.aluop = 1; e.a = rsv; e.b = rtv; e.wr = ins[15:11]; end
        else return '0;
      end
      6'h0d: begin e.aluop = 2; e.a = rsv; e.b = zimm; e.wr = ins[20:16]; end
      6'h0f: begin e.aluop = 3; e.a = 0;   e.b = zimm; e.wr = ins[20:16]; end
      6'h23: begin e.aluop = 0; e.a = rsv; e.b = simm; e.wr = ins[20:16]; e.mr = 1; end
      6'h2b: begin e.aluop = 0; e.a = rsv; e.b = simm; e.mw = 1; end
      6'h04: begin e.aluop = 1; e.a = rsv; e.b = rtv; end
      default: return '0;
    endcase
    e.rt = rtv;
    e.rw = (e.wr != 0);
    e.v  = 1;
    return e;
  endfunction

  function automatic bit model_hazard(exp_t e, logic [31:0] ins, logic vld);
    bit r_rs, r_rt;
    r_rs = 0;
    r_rt = 0;
    if (!(e.v && e.mr && e.wr != 0) || !vld) return 0;
    case (ins[31:26])
      6'h00: if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) begin r_rs = 1; r_rt = 1; end
      6'h0d, 6'h23: r_rs = 1;
      6'h2b, 6'h04: begin r_rs = 1; r_rt = 1; end
      default: ;
    endcase
    return (r_rs && ins[25:21] == e.wr) || (r_rt && ins[20:16] == e.wr);
  endfunction

  always @(posedge clk) begin
    exp_t nxt;
    bit   hz;
    hz = model_hazard(m_e, instr_d, valid_d) && !stall_ext;
    if (reset || flush) nxt = '0;
    else if (stall_ext) nxt = m_e;
    else if (hz)        nxt = '0;
    else nxt = model_issue(instr_d, valid_d, src_val(instr_d[25:21], rs_data),
                           src_val(instr_d[20:16], rt_data));
    m_e = nxt;
    exp_q.push_back(nxt);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("e_stage", {ALUOP, ALU_A, ALU_B, rt_e, wr_reg_e, reg_write_e,
                        mem_read_e, mem_write_e, valid_e}, e);
      check("stall_d", stall_d, model_hazard(m_e, instr_d, valid_d) && !stall_ext);
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic set_in(logic [31:0] ins, logic vld, logic [31:0] rsv, logic [31:0] rtv,
                        logic fl = 0, logic se = 0, logic rst = 0);
    instr_d = ins; valid_d = vld; rs_data = rsv; rt_data = rtv;
    flush = fl; stall_ext = se; reset = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [5:0] ADDU = 6'h21, SUBU = 6'h23;

  initial begin
    fwd_m_we = 0; fwd_m_reg = 0; fwd_m_data = 0;
    fwd_w_we = 0; fwd_w_reg = 0; fwd_w_data = 0;
    set_in(32'h0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    check("rst_valid", valid_e, 0);
    check("rst_a", ALU_A, 0);
    check("rst_stall", stall_d, 0);

    set_in(rtype(1, 2, 3, ADDU), 1, 5, 7); tick();
    check("addu_op", ALUOP, 4'b0000);
    check("addu_a", ALU_A, 5);
    check("addu_b", ALU_B, 7);
    check("addu_wr", wr_reg_e, 3);
    check("addu_rw", reg_write_e, 1);

    set_in(itype(6'h0f, 0, 4, 16'h1234), 1, 32'h99, 32'h77); tick();
    check("lui_op", ALUOP, 4'b0011);
    check("lui_b", ALU_B, 32'h00001234);
    check("lui_wr", wr_reg_e, 4);

    set_in(rtype(1, 2, 7, SUBU), 1, 10, 3); tick();
    check("subu_op", ALUOP, 4'b0001);
    check("subu_b", ALU_B, 3);

    set_in(itype(6'h0d, 1, 8, 16'h8001), 1, 32'hF0, 0); tick();
    check("ori_op", ALUOP, 4'b0010);
    check("ori_b_zext", ALU_B, 32'h00008001);

    // Load-use: lw $5,-4($1) then addu $6,$5,$0
    set_in(itype(6'h23, 1, 5, 16'hFFFC), 1, 32'h100, 0); tick();
    check("lw_b_sext", ALU_B, 32'hFFFFFFFC);
    check("lw_mr", mem_read_e, 1);
    set_in(rtype(5, 0, 6, ADDU), 1, 3, 0); #1;
    check("lu_stall", stall_d, 1);
    tick();
    check("lu_bubble", valid_e, 0);
    #1 check("lu_stall_drop", stall_d, 0);
    tick();
    check("lu_issue_v", valid_e, 1);
    check("lu_issue_wr", wr_reg_e, 6);

    // Freeze for three cycles, then flush during freeze
    set_in(itype(6'h0d, 2, 9, 16'h00FF), 1, 32'h100, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(rtype(1, 2, 3, ADDU), 1, 1, 1, 0, 1); tick();
      check("hold_b", ALU_B, 32'hFF);
      check("hold_wr", wr_reg_e, 9);
    end
    set_in(rtype(1, 2, 3, ADDU), 1, 1, 1, 1, 1); tick();
    check("flush_frz_v", valid_e, 0);

    set_in(itype(6'h2b, 1, 2, 16'h0008), 1, 32'h40, 32'hDEAD); tick();
    check("sw_mw", mem_write_e, 1);
    check("sw_rt", rt_e, 32'hDEAD);
    check("sw_rw", reg_write_e, 0);
    set_in(itype(6'h04, 1, 2, 16'h0010), 1, 9, 9); tick();
    check("beq_op", ALUOP, 4'b0001);
    check("beq_b", ALU_B, 9);
    set_in(rtype(1, 2, 0, ADDU), 1, 4, 4); tick();
    check("dest0_rw", reg_write_e, 0);
    set_in(32'h0, 1, 4, 4); tick();
    check("nop_v", valid_e, 0);
    set_in(rtype(1, 2, 3, ADDU), 0, 4, 4); tick();
    check("vld0_v", valid_e, 0);
    set_in(32'hFC00_0000, 1, 4, 4); tick();
    check("illegal_v", valid_e, 0);

    // Reset during load-use stall
    set_in(itype(6'h23, 1, 5, 16'h0004), 1, 32'h10, 0); tick();
    set_in(rtype(5, 0, 6, ADDU), 1, 3, 0, 0, 0, 1); #1;
    check("rst_mid_stall_pre", stall_d, 1);
    tick();
    check("rst_mid_v", valid_e, 0);
    check("rst_mid_b", ALU_B, 0);
    check("rst_mid_stall", stall_d, 0);

    // Flush with load-use stall pending
    set_in(itype(6'h23, 1, 5, 16'h0004), 1, 32'h10, 0); tick();
    set_in(rtype(5, 0, 6, ADDU), 1, 3, 0, 1); #1;
    check("fl_stall", stall_d, 1);
    tick();
    check("fl_bubble", valid_e, 0);

    // lw to $0 never stalls; lui ignores rs; sw store data hazard on rt
    set_in(itype(6'h23, 1, 0, 16'h0004), 1, 32'h10, 0); tick();
    set_in(rtype(0, 0, 6, ADDU), 1, 0, 0); #1;
    check("lw0_nostall", stall_d, 0);
    tick();
    set_in(itype(6'h23, 1, 5, 16'h0004), 1, 32'h10, 0); tick();
    set_in(itype(6'h0f, 5, 7, 16'h0001), 1, 0, 0); #1;
    check("lui_nostall", stall_d, 0);
    tick();
    set_in(itype(6'h23, 1, 5, 16'h0004), 1, 32'h10, 0); tick();
    set_in(itype(6'h2b, 1, 5, 16'h0000), 1, 0, 0); #1;
    check("sw_rt_stall", stall_d, 1);
    tick(); tick();

    // Mixed directed-pattern run with random data; scoreboard checks each cycle
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 6)); b = 5'($urandom_range(0, 6)); c = 5'($urandom_range(0, 6));
      case ($urandom_range(0, 7))
        0: ins = rtype(a, b, c, ADDU);
        1: ins = rtype(a, b, c, SUBU);
        2: ins = itype(6'h0d, a, b, 16'($urandom));
        3: ins = itype(6'h0f, a, b, 16'($urandom));
        4: ins = itype(6'h23, a, b, 16'($urandom));
        5: ins = itype(6'h2b, a, b, 16'($urandom));
        6: ins = itype(6'h04, a, b, 16'($urandom));
        default: ins = $urandom;
      endcase
      set_in(ins, 1'($urandom_range(0, 7) != 0), $urandom, $urandom,
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0));
      tick();
    end
    set_in(32'h0, 0, 0, 0); tick();

`ifdef ALU_ISSUE_FWD_EN
    fwd_m_we = 1; fwd_m_reg = 1; fwd_m_data = 32'hAA;
    fwd_w_we = 1; fwd_w_reg = 1; fwd_w_data = 32'hBB;
    set_in(rtype(1, 2, 3, ADDU), 1, 5, 7); tick();
    check("fwd_m_prio", ALU_A, 32'hAA);
    fwd_m_we = 0;
    set_in(rtype(2, 1, 3, ADDU), 1, 5, 7); tick();
    check("fwd_w_rt", ALU_B, 32'hBB);
    fwd_m_we = 1; fwd_m_reg = 0; fwd_w_reg = 0;
    set_in(rtype(0, 0, 3, ADDU), 1, 32'h11, 32'h22); tick();
    check("fwd_zero_a", ALU_A, 32'h11);
    check("fwd_zero_b", ALU_B, 32'h22);
    fwd_m_we = 0; fwd_w_we = 0;
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
